control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Main control decoder for the single-issue RV64 core, sitting between fetch/decode and the datapath.
//   Decodes opcode instruction[6:0] into datapath steering signals (branch, memory, writeback, ALU-op class).
//   Outputs are registered: one cycle of latency, pipeline-register style.
//   Also flags unsupported opcodes.
// PARAMETERS
//   none (the decode table is fixed; the I-type ALU decode is a compile-time option)
// PORTS
//   clk          in   1   single clock; all state updates on posedge
//   rst          in   1   reset, synchronous, active-high
//   instruction  in   32  instruction word; only [6:0] is decoded, [31:7] are ignored
//   in_valid     in   1   instruction is valid this cycle
//   hold         in   1   stall: keep all outputs unchanged
//   branch       out  1   conditional branch
//   mem_read     out  1   data-memory read
//   mem_reg      out  1   writeback source: 1 = memory data, 0 = ALU result
//   mem_write    out  1   data-memory write
//   alu_src      out  1   ALU operand B: 1 = immediate, 0 = rs2
//   reg_write    out  1   register-file write enable
//   ALU_op       out  2   ALU-control class: 00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
//   out_valid    out  1   outputs correspond to a valid instruction
//   illegal      out  1   valid instruction with an unsupported opcode
// BEHAVIOUR
//   - Reset: on posedge clk with rst=1, every output (branch..ALU_op, out_valid, illegal) goes to 0.
//     rst has priority over hold and in_valid.
//   - Latency: controls for the instruction sampled at edge N are visible after edge N, held until the next update.
//   - hold=1 (rst=0): all output registers keep their values; instruction and in_valid are ignored.
//   - in_valid=0 (rst=0, hold=0): bubble. All control outputs = 0; out_valid = 0; illegal = 0.
//   - in_valid=1: out_valid = 1; controls are loaded from the decode table.
//   - Decode table, opcode -> branch,mem_read,mem_reg,mem_write,alu_src,reg_write,ALU_op:
//       0110011 R-type : 0,0,0,0,0,1,10
//       0000011 load   : 0,1,1,0,1,1,00
//       0100011 store  : 0,0,0,1,1,0,00
//       1100011 branch : 1,0,0,0,0,0,01
//   - Any other opcode: all controls = 0, ALU_op = 00, illegal = 1.
//     Controls are never X; don't-care fields (e.g. mem_reg for store/branch) are driven 0.
//   - The decode is purely a function of instruction[6:0]; funct3/funct7 never affect the outputs.
//   - Invariants, enforced by construction and checked by the bench:
//       mem_read & mem_write == 0
//       branch implies reg_write == 0
//       illegal implies no write enables
// CONFIGURATION
//   CONTROL_ITYPE_EN defined:
//     0010011 (OP-IMM) decodes as 0,0,0,0,1,1,11 (immediate ALU, register writeback), illegal = 0.
//   CONTROL_ITYPE_EN undefined:
//     0010011 is treated as an unsupported opcode (all controls 0, illegal = 1).
// TESTING
//   1) rst=1 for 2 cycles with instruction=0x00000033, in_valid=1
//      -> all outputs 0 after each edge; after release, next edge gives R-type controls.
//   2) in_valid=1, instruction 0x00000033, 0x00000003, 0x00000023, 0x00000063 on consecutive edges
//      -> one cycle later each: R {0,0,0,0,0,1,10}, load {0,1,1,0,1,1,00},
//         store {0,0,0,1,1,0,00}, branch {1,0,0,0,0,0,01}; out_valid = 1, illegal = 0.
//   3) instruction 0x0000007F (and 0x00000013 without CONTROL_ITYPE_EN), in_valid=1
//      -> all controls 0, illegal = 1, out_valid = 1.
//   4) load decoded, then hold=1 for 3 cycles while instruction=0x00000023
//      -> load controls persist; store controls appear one edge after hold drops.
//   5) in_valid=0 with instruction=0x00000003
//      -> all outputs 0 (bubble); upper bits [31:7] randomised with a fixed opcode give identical outputs.
//   6) With CONTROL_ITYPE_EN defined: instruction 0x00000013
//      -> {0,0,0,0,1,1,11}, illegal = 0; invariants asserted every cycle across a random opcode sweep.

Source files
------------

// File: rtl/control_unit.sv
// Main control decoder: registers datapath steering controls decoded from instruction[6:0].
// Optional OP-IMM (0010011) decode is enabled by defining CONTROL_ITYPE_EN.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        in_valid,
  input  logic        hold,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  ALU_op,
  output logic        out_valid,
  output logic        illegal
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
`ifdef CONTROL_ITYPE_EN
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_RFUNC = 2'b10;
`ifdef CONTROL_ITYPE_EN
  localparam logic [ALUOP_W-1:0] ALU_IFUNC = 2'b11;
`endif

  typedef struct packed {
    logic               branch;
    logic               mem_read;
    logic               mem_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

  logic [OPC_W-1:0] w_opcode;
  logic             w_unused_upper;
  ctrl_t            w_dec;
  ctrl_t            r_ctrl;
  logic             r_valid;

  assign w_opcode       = instruction[OPC_W-1:0];
  // funct3/funct7 and operand fields never influence the control decode
  assign w_unused_upper = ^instruction[31:OPC_W];

  // Opcode decode table; unlisted fields stay 0 so no control is ever X
  always_comb begin
    w_dec = '0;
    case (w_opcode)
      OPC_RTYPE: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALU_RFUNC;
      end
      OPC_LOAD: begin
        w_dec.mem_read  = 1'b1;
        w_dec.mem_reg   = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALU_ADD;
      end
      OPC_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_ADD;
      end
      OPC_BRANCH: begin
        w_dec.branch    = 1'b1;
        w_dec.alu_op    = ALU_SUB;
      end
`ifdef CONTROL_ITYPE_EN
      OPC_OPIMM: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALU_IFUNC;
      end
`endif
      default: begin
        w_dec.illegal   = 1'b1;
      end
    endcase
  end

  // Pipeline register: reset beats hold, hold freezes, bubble clears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_ctrl  <= in_valid ? w_dec : '0;
      r_valid <= in_valid;
    end
  end

  assign branch    = r_ctrl.branch;
  assign mem_read  = r_ctrl.mem_read;
  assign mem_reg   = r_ctrl.mem_reg;
  assign mem_write = r_ctrl.mem_write;
  assign alu_src   = r_ctrl.alu_src;
  assign reg_write = r_ctrl.reg_write;
  assign ALU_op    = r_ctrl.alu_op;
  assign out_valid = r_valid;
  assign illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control vectors plus per-cycle invariant checks.
// Define CONTROL_ITYPE_EN for both bench and RTL to cover the OP-IMM decode.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        in_valid;
  logic        hold;
  logic        branch, mem_read, mem_reg, mem_write, alu_src, reg_write;
  logic [1:0]  ALU_op;
  logic        out_valid, illegal;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  // {branch,mem_read,mem_reg,mem_write,alu_src,reg_write,ALU_op[1:0],out_valid,illegal}
  localparam logic [9:0] EXP_ZERO   = 10'b0000000000;
  localparam logic [9:0] EXP_RTYPE  = 10'b0000011010;
  localparam logic [9:0] EXP_LOAD   = 10'b0110110010;
  localparam logic [9:0] EXP_STORE  = 10'b0001100010;
  localparam logic [9:0] EXP_BRANCH = 10'b1000000110;
  localparam logic [9:0] EXP_ILL    = 10'b0000000011;
  localparam logic [9:0] EXP_OPIMM  = 10'b0000111110;

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .in_valid    (in_valid),
    .hold        (hold),
    .branch      (branch),
    .mem_read    (mem_read),
    .mem_reg     (mem_reg),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .reg_write   (reg_write),
    .ALU_op      (ALU_op),
    .out_valid   (out_valid),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {branch, mem_read, mem_reg, mem_write, alu_src, reg_write, ALU_op, out_valid, illegal};
  endfunction

  // Reference table written from the decode description
  function automatic logic [9:0] model(input logic v, input logic [6:0] opc);
    if (!v) return EXP_ZERO;
    case (opc)
      7'b0110011: return EXP_RTYPE;
      7'b0000011: return EXP_LOAD;
      7'b0100011: return EXP_STORE;
      7'b1100011: return EXP_BRANCH;
`ifdef CONTROL_ITYPE_EN
      7'b0010011: return EXP_OPIMM;
`endif
      default:    return EXP_ILL;
    endcase
  endfunction

  task automatic drive(input logic r, input logic h, input logic v, input logic [31:0] ins);
    @(negedge clk);
    rst = r; hold = h; in_valid = v; instruction = ins;
    @(posedge clk);
    #1;
  endtask

  // Structural invariants, every cycle once reset has been applied
  always @(negedge clk) begin
    if (inv_on) begin
      check_eq("inv_rd_wr", 32'(mem_read & mem_write), 32'd0);
      check_eq("inv_br_rw", 32'(branch & reg_write), 32'd0);
      check_eq("inv_ill_we", 32'(illegal & (reg_write | mem_write)), 32'd0);
    end
  end

  initial begin
    logic [31:0] rnd;
    logic [6:0]  opc;
    logic        v;

    rst = 1'b1; hold = 1'b0; in_valid = 1'b1; instruction = 32'h0000_0033;

    // Reset with a valid R-type pending, then release
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0033);
    check_eq("rst_cyc1", 32'(obs()), 32'(EXP_ZERO));
    inv_on = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0033);
    check_eq("rst_cyc2", 32'(obs()), 32'(EXP_ZERO));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0033);
    check_eq("rst_release_r", 32'(obs()), 32'(EXP_RTYPE));

    // Back-to-back decode of the four supported classes
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0003);
    check_eq("dec_load", 32'(obs()), 32'(EXP_LOAD));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0023);
    check_eq("dec_store", 32'(obs()), 32'(EXP_STORE));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0063);
    check_eq("dec_branch", 32'(obs()), 32'(EXP_BRANCH));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0033);
    check_eq("dec_rtype", 32'(obs()), 32'(EXP_RTYPE));

    // Unsupported opcodes, and OP-IMM depending on build option
    drive(1'b0, 1'b0, 1'b1, 32'h0000_007F);
    check_eq("dec_ill_7f", 32'(obs()), 32'(EXP_ILL));
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0013);
`ifdef CONTROL_ITYPE_EN
    check_eq("dec_opimm", 32'(obs()), 32'(EXP_OPIMM));
`else
    check_eq("dec_opimm_ill", 32'(obs()), 32'(EXP_ILL));
`endif
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    check_eq("dec_ill_00", 32'(obs()), 32'(EXP_ILL));

    // Hold freezes a decoded load while a store waits on the input
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0003);
    check_eq("hold_pre_load", 32'(obs()), 32'(EXP_LOAD));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0023);
      check_eq($sformatf("hold_keep%0d", i), 32'(obs()), 32'(EXP_LOAD));
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0023);
    check_eq("hold_release_st", 32'(obs()), 32'(EXP_STORE));

    // Hold with invalid input also freezes; reset overrides hold
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0063);
    check_eq("hold_ignore_inv", 32'(obs()), 32'(EXP_STORE));
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0063);
    check_eq("rst_over_hold", 32'(obs()), 32'(EXP_ZERO));

    // Bubble clears everything
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0063);
    check_eq("pre_bubble_br", 32'(obs()), 32'(EXP_BRANCH));
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0003);
    check_eq("bubble_load", 32'(obs()), 32'(EXP_ZERO));

    // Upper instruction bits never change the decode
    for (int i = 0; i < 8; i++) begin
      rnd = $urandom();
      drive(1'b0, 1'b0, 1'b1, {rnd[31:7], 7'b0000011});
      check_eq($sformatf("upper_load%0d", i), 32'(obs()), 32'(EXP_LOAD));
      rnd = $urandom();
      drive(1'b0, 1'b0, 1'b1, {rnd[31:7], 7'b1100011});
      check_eq($sformatf("upper_br%0d", i), 32'(obs()), 32'(EXP_BRANCH));
      rnd = $urandom();
      drive(1'b0, 1'b0, 1'b0, {rnd[31:7], 7'b0000011});
      check_eq($sformatf("upper_bub%0d", i), 32'(obs()), 32'(EXP_ZERO));
    end

    // Random opcode sweep, biased toward legal opcodes
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom();
      case (rnd[2:0])
        3'd0:    opc = 7'b0110011;
        3'd1:    opc = 7'b0000011;
        3'd2:    opc = 7'b0100011;
        3'd3:    opc = 7'b1100011;
        3'd4:    opc = 7'b0010011;
        default: opc = rnd[14:8];
      endcase
      v = (rnd[5:3] != 3'd0);
      drive(1'b0, 1'b0, v, {rnd[31:15], 8'h00, opc});
      check_eq($sformatf("sweep%0d_op%02h", i, opc), 32'(obs()), 32'(model(v, opc)));
    end

    @(negedge clk);
    inv_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
